uart_tx_mmio: RTL and testbench
===============================

Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the CPU data bus, directly downstream of the CPU's store path.
- A CPU store to the UART data address pushes one byte into a transmit FIFO. The block serialises FIFO bytes onto `tx` as 8N1 frames.
- A status register lets software poll for FIFO full, transmitter busy and a sticky overflow flag.
- Sits beside the byte-lane BRAMs on the same `mem_addr`/`wr_mem` bus; its read data is muxed into the CPU's `rd_data` by the top level.

Parameters:
- CLOCK_HZ, 27_000_000, system clock frequency.
- BAUD, 115_200, line rate; DIV = CLOCK_HZ / BAUD (integer division, must be ≥ 2).
- DEPTH, 16, FIFO entries (power of two, ≥ 2).
- DATA_ADDR, 'h082, byte address of the data register (write-only).
- STAT_ADDR, 'h084, byte address of the status register.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- addr  in  ADDR_WIDTH  CPU byte address.
- wr  in  1  CPU write strobe, one cycle per store.
- wr_data  in  8  CPU write data (low byte of the bus).
- rd_data  out  8  registered read data for STAT_ADDR; 0 for all other addresses.
- tx  out  1  serial output, idle high.
- irq_empty  out  1  high while FIFO empty and FSM idle.

Behaviour:
- Reset: rst, asynchronous, active-high; clock clk.
- Outputs while rst is high: tx=1, rd_data=0, irq_empty=1. FIFO empty, overflow=0, FSM=IDLE, baud counter=0, bit index=0.
- Reset mid-frame aborts the frame immediately (tx forced to 1 asynchronously); queued bytes are discarded.
- Push:
  - Condition: wr && addr==DATA_ADDR.
  - Accepted if FIFO not full, or if full and a pop occurs on the same edge. In the full-with-pop case the count is unchanged.
  - Otherwise the byte is dropped and overflow is set.
- Status write: wr && addr==STAT_ADDR && wr_data[2]==1 clears overflow. A set in the same cycle wins over the clear.
- Status read:
  - rd_data is registered, one cycle latency (matches BRAM read latency).
  - Value sampled at the edge where addr==STAT_ADDR: {5'b0, overflow, busy, full}.
  - busy = FIFO non-empty OR FSM≠IDLE.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO non-empty: pop head into shift register, counter=0, go to START.
  - START: tx=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for DIV cycles, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: tx=1 for DIV cycles. Then, if FIFO non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Latency: push accepted at edge E0 → pop and START at edge E1 → tx low from E1. Frame = 10·DIV cycles.
- Baud counter: counts 0..DIV-1 and wraps; the state/bit advance fires on the DIV-1 → 0 wrap.
- FIFO: read/write pointers are log2(DEPTH)+1 bits wide. Empty when pointers are equal. Full when the MSBs differ and the low bits are equal.
- irq_empty: registered, equal to !busy.

Decomposition:
- uart_pkg:
  - typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t.
  - Status bit indices: ST_FULL=0, ST_BUSY=1, ST_OVF=2.
  - Default address constants.
- Sub-module sync_fifo (params WIDTH=8, DEPTH): push/pop/din/dout/full/empty.
  - dout shows the head combinationally.
  - Same async reset.

Test Plan:
- DIV=4, write 0x41 at E0 → tx low E1..E4; data bits 1,0,0,0,0,0,1,0 for 4 cycles each; stop high 4 cycles; busy=1 during the frame, 0 after 40 cycles; irq_empty rises one cycle later.
- Write 0x55, 0xAA, 0x0F on consecutive cycles → three contiguous 40-cycle frames, each start bit immediately following the previous stop bit; decoded bytes match.
- DEPTH=4, write 6 bytes on consecutive cycles → exactly 5 frames transmitted, 6th byte absent; status read returns 0x07 while full, then 0x06. Writing 0x04 to STAT_ADDR → status 0x02 (busy only).
- Assert rst for 3 cycles during DATA bit 3 of a frame with 2 bytes queued → tx=1 within the rst cycle, status=0x00 after release, no further frames.
- Read addr 0x080 and STAT_ADDR on alternate cycles while idle → rd_data 0x00 and 0x00, each one cycle after the address.
- Push into a full FIFO on the exact STOP→START pop edge → byte accepted, overflow stays 0, all bytes transmitted in order.

Source files
------------

// File: rtl/uart_tx_mmio_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// The package is called uart_pkg because the FIFO and the top both import it.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  // Bit positions inside the status register.
  localparam int ST_FULL = 0;
  localparam int ST_BUSY = 1;
  localparam int ST_OVF  = 2;

  localparam int          DEF_ADDR_WIDTH = 12;
  localparam logic [11:0] DEF_DATA_ADDR  = 12'h082;
  localparam logic [11:0] DEF_STAT_ADDR  = 12'h084;

  function automatic int calc_div(input int clock_hz, input int baud);
    return clock_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// CPU store/load bus seen by the UART: address, write strobe, write data
// and the registered read data that the top level muxes into rd_data.
interface uart_tx_mmio_if #(
  parameter int ADDR_WIDTH = 12
) ();
  logic [ADDR_WIDTH-1:0] addr;
  logic                  wr;
  logic [7:0]            wr_data;
  logic [7:0]            rd_data;

  modport master (output addr, output wr, output wr_data, input  rd_data);
  modport slave  (input  addr, input  wr, input  wr_data, output rd_data);
endinterface

// File: rtl/uart_tx_mmio_fifo.sv
// Transmit FIFO with extended pointers (one wrap bit) and a combinational head.
// A push into a full FIFO is taken only when a pop happens on the same edge.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: stores to DATA_ADDR queue bytes,
// STAT_ADDR reads {overflow, busy, full} and writing bit 2 clears overflow.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int                    CLOCK_HZ   = 27_000_000,
  parameter int                    BAUD       = 115_200,
  parameter int                    DEPTH      = 16,
  parameter int                    ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] DATA_ADDR  = 'h082,
  parameter logic [ADDR_WIDTH-1:0] STAT_ADDR  = 'h084
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_mmio_if.slave        bus,
  output logic                 tx,
  output logic                 irq_empty
);
  localparam int DIV = calc_div(CLOCK_HZ, BAUD);
  localparam int CW  = $clog2(DIV);

  uart_tx_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           ovf_q, ovf_d;
  logic [7:0]     rd_data_q, rd_data_d;
  logic           irq_q, irq_d;

  logic           fifo_pop;
  logic [7:0]     fifo_dout;
  logic           fifo_full;
  logic           fifo_empty;
  logic           push_req;
  logic           stat_hit;
  logic           wrap;
  logic           busy;
  logic [7:0]     status;

  assign push_req = bus.wr && (bus.addr == DATA_ADDR);
  assign stat_hit = (bus.addr == STAT_ADDR);
  assign wrap     = (cnt_q == CW'(DIV - 1));
  assign busy     = !fifo_empty || (state_q != IDLE);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (fifo_pop),
    .din   (bus.wr_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // tx is registered from the next-state decode so the line never glitches
  // and drops low on the same edge that pops the byte.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          state_d  = START;
          tx_d     = 1'b0;
        end
      end
      START: begin
        cnt_d = cnt_q + 1'b1;
        if (wrap) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = DATA;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (wrap) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            tx_d      = shift_q[1];
          end
        end
      end
      STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (wrap) begin
          cnt_d = '0;
          // Back-to-back frames: next start bit follows the stop bit directly.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = START;
            tx_d     = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_comb begin
    status          = '0;
    status[ST_FULL] = fifo_full;
    status[ST_BUSY] = busy;
    status[ST_OVF]  = ovf_q;

    rd_data_d = stat_hit ? status : 8'h00;
    irq_d     = !busy;

    // A dropped byte in the same cycle as a clear keeps the flag set.
    ovf_d = ovf_q;
    if (push_req && fifo_full && !fifo_pop)
      ovf_d = 1'b1;
    else if (bus.wr && stat_hit && bus.wr_data[ST_OVF])
      ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      ovf_q     <= 1'b0;
      rd_data_q <= 8'h00;
      irq_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
      irq_q     <= irq_d;
    end
  end

  assign tx          = tx_q;
  assign irq_empty   = irq_q;
  assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed plus random stimulus for uart_tx_mmio, checked each cycle against a
// frame-schedule model of the line (byte queue, frame start times, 10*DIV frames).
module tb_uart_tx_mmio;
  localparam int          DIV   = 4;
  localparam int          DEPTH = 4;
  localparam logic [11:0] DATA  = 12'h082;
  localparam logic [11:0] STAT  = 12'h084;
  localparam logic [11:0] OTHER = 12'h080;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;
  logic irq_empty;

  uart_tx_mmio_if #(.ADDR_WIDTH(12)) bus ();

  uart_tx_mmio #(
    .CLOCK_HZ   (400),
    .BAUD       (100),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (12),
    .DATA_ADDR  (DATA),
    .STAT_ADDR  (STAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .tx        (tx),
    .irq_empty (irq_empty)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] q[$];
  logic       in_frame;
  int         t;
  logic [7:0] cur;
  logic       m_ovf;
  logic [7:0] m_rd;
  logic       m_irq;
  logic       m_tx;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    in_frame = 1'b0;
    t        = 0;
    cur      = 8'h00;
    m_ovf    = 1'b0;
    m_rd     = 8'h00;
    m_irq    = 1'b1;
    m_tx     = 1'b1;
  endtask

  // Applies one clock edge to the model using the inputs the DUT saw.
  task automatic model_edge();
    int   size_pre;
    int   b;
    logic busy_pre, full_pre, pop, set;
    if (rst) begin
      model_reset();
      return;
    end
    size_pre = q.size();
    busy_pre = (size_pre != 0) || in_frame;
    full_pre = (size_pre == DEPTH);
    m_rd  = (bus.addr == STAT) ? {5'b0, m_ovf, busy_pre, full_pre} : 8'h00;
    m_irq = !busy_pre;
    if (in_frame) begin
      t++;
      if (t == 10 * DIV) in_frame = 1'b0;
    end
    pop = !in_frame && (size_pre != 0);
    if (pop) begin
      cur      = q.pop_front();
      in_frame = 1'b1;
      t        = 0;
    end
    set = 1'b0;
    if (bus.wr && bus.addr == DATA) begin
      if (size_pre < DEPTH || pop) q.push_back(bus.wr_data);
      else set = 1'b1;
    end
    if (set) m_ovf = 1'b1;
    else if (bus.wr && bus.addr == STAT && bus.wr_data[2]) m_ovf = 1'b0;
    if (!in_frame) m_tx = 1'b1;
    else begin
      b = t / DIV;
      if (b == 0)      m_tx = 1'b0;
      else if (b == 9) m_tx = 1'b1;
      else             m_tx = cur[b-1];
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("tx", {7'b0, tx}, {7'b0, m_tx});
    check("rd_data", bus.rd_data, m_rd);
    check("irq_empty", {7'b0, irq_empty}, {7'b0, m_irq});
  endtask

  task automatic do_write(input logic [11:0] a, input logic [7:0] d);
    bus.addr    = a;
    bus.wr      = 1'b1;
    bus.wr_data = d;
    step();
    $display("write addr=0x%03h data=0x%02h queued=%0d ovf=%0d", a, d, q.size(), m_ovf);
    bus.wr = 1'b0;
  endtask

  task automatic idle(input int n, input logic [11:0] a);
    bus.wr   = 1'b0;
    bus.addr = a;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int r;
    model_reset();
    bus.addr    = '0;
    bus.wr      = 1'b0;
    bus.wr_data = 8'h00;

    // Reset held for three edges
    idle(3, STAT);
    rst = 1'b0;
    idle(2, STAT);
    check("reset_status", bus.rd_data, 8'h00);

    // Idle reads of an unrelated address and the status register alternate
    for (int i = 0; i < 4; i++) begin
      idle(1, OTHER);
      check("other_rd", bus.rd_data, 8'h00);
      idle(1, STAT);
      check("idle_stat", bus.rd_data, 8'h00);
    end

    // Single frame 0x41
    do_write(DATA, 8'h41);
    idle(1, STAT);
    check("first_start_bit", {7'b0, tx}, 8'h00);
    idle(44, STAT);
    check("irq_after_frame", {7'b0, irq_empty}, 8'h01);

    // Three contiguous frames
    do_write(DATA, 8'h55);
    do_write(DATA, 8'hAA);
    do_write(DATA, 8'h0F);
    idle(125, STAT);

    // Overflow with DEPTH=4: six writes, five accepted
    for (int i = 0; i < 6; i++) do_write(DATA, 8'h30 + 8'(i));
    idle(1, STAT);
    check("status_full_ovf", bus.rd_data, 8'h07);
    idle(60, STAT);
    do_write(STAT, 8'h04);
    idle(1, STAT);
    check("status_cleared", bus.rd_data, 8'h02);
    idle(200, STAT);

    // Push into a full FIFO on the STOP->START pop edge
    for (int i = 0; i < 5; i++) do_write(DATA, 8'hC0 + 8'(i));
    idle(36, STAT);
    do_write(DATA, 8'hE7);
    idle(1, STAT);
    check("pop_edge_no_ovf", {7'b0, bus.rd_data[2]}, 8'h00);
    idle(220, STAT);

    // Asynchronous reset during data bit 3 with two bytes queued
    do_write(DATA, 8'h96);
    do_write(DATA, 8'h69);
    do_write(DATA, 8'h3C);
    idle(16, STAT);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_tx", {7'b0, tx}, 8'h01);
    check("async_rst_irq", {7'b0, irq_empty}, 8'h01);
    model_reset();
    idle(3, STAT);
    rst = 1'b0;
    idle(1, STAT);
    check("post_rst_status", bus.rd_data, 8'h00);
    idle(60, STAT);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      r = int'($urandom_range(0, 19));
      if (r < 3)       do_write(DATA, 8'($urandom));
      else if (r == 3) do_write(STAT, 8'($urandom));
      else if (r < 12) idle(1, STAT);
      else if (r < 14) idle(1, OTHER);
      else             idle(1, 12'($urandom));
    end
    idle(10 * DIV * (DEPTH + 2), STAT);
    check("drained_irq", {7'b0, irq_empty}, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
